// File: rtl/ecc_apb_driver_if.sv
// APB write-side bus between the ECC stimulus driver (master) and the ECC register bank (slave).
interface ecc_apb_driver_if #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20
);
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_WORD-1:0]       PWDATA;

    modport master (
        output PADDR,
        output PSEL,
        output PENABLE,
        output PWRITE,
        output PWDATA
    );

    modport slave (
        input PADDR,
        input PSEL,
        input PENABLE,
        input PWRITE,
        input PWDATA
    );
endinterface

// File: rtl/ecc_apb_driver.sv
// Turns one ECC job into four APB writes (DATA_IN, CODEWORD_WIDTH, NOISE, CTRL), waits for
// operation_done or a timeout, and hands the captured result back on a valid/ready port.
module ecc_apb_driver #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [1:0]            job_ctrl,
    input  logic [DATA_WIDTH-1:0] job_data,
    input  logic [1:0]            job_width,
    input  logic [DATA_WIDTH-1:0] job_noise,
    ecc_apb_driver_if.master      apb,
    input  logic                  operation_done,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic [1:0]            num_of_errors,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [1:0]            res_errors,
    output logic                  res_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CTRL    = AMBA_ADDR_WIDTH'(32'h00);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_DATA_IN = AMBA_ADDR_WIDTH'(32'h04);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_WIDTH   = AMBA_ADDR_WIDTH'(32'h08);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_NOISE   = AMBA_ADDR_WIDTH'(32'h0C);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        WAIT_DONE,
        RESULT
    } state_t;

    state_t                     state_q, state_n;
    logic [1:0]                 k_q, k_n;
    logic [CNT_W-1:0]           cnt_q, cnt_n;
    logic [1:0]                 ctrl_q, ctrl_n;
    logic [DATA_WIDTH-1:0]      data_q, data_n;
    logic [1:0]                 width_q, width_n;
    logic [DATA_WIDTH-1:0]      noise_q, noise_n;
    logic [DATA_WIDTH-1:0]      res_data_q, res_data_n;
    logic [1:0]                 res_errors_q, res_errors_n;
    logic                       res_timeout_q, res_timeout_n;
    logic                       job_ready_q, job_ready_n;
    logic                       res_valid_q, res_valid_n;
    logic                       psel_q, psel_n;
    logic                       penable_q, penable_n;
    logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_n;
    logic [AMBA_WORD-1:0]       pwdata_q, pwdata_n;

    // Next state plus every output derived from the next state, so all outputs leave a flop.
    always_comb begin
        state_n       = state_q;
        k_n           = k_q;
        cnt_n         = cnt_q;
        ctrl_n        = ctrl_q;
        data_n        = data_q;
        width_n       = width_q;
        noise_n       = noise_q;
        res_data_n    = res_data_q;
        res_errors_n  = res_errors_q;
        res_timeout_n = res_timeout_q;

        unique case (state_q)
            IDLE: begin
                if (job_valid) begin
                    ctrl_n  = job_ctrl;
                    data_n  = job_data;
                    width_n = job_width;
                    noise_n = job_noise;
                    k_n     = 2'd0;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                state_n = ACCESS;
            end
            ACCESS: begin
                if (k_q == 2'd3) begin
                    cnt_n   = '0;
                    state_n = WAIT_DONE;
                end else begin
                    k_n     = k_q + 2'd1;
                    state_n = SETUP;
                end
            end
            WAIT_DONE: begin
                // A done arriving on the last allowed cycle still counts as success.
                if (operation_done) begin
                    res_data_n    = data_out;
                    res_errors_n  = num_of_errors;
                    res_timeout_n = 1'b0;
                    state_n       = RESULT;
                end else if (cnt_q == CNT_LAST) begin
                    res_data_n    = '0;
                    res_errors_n  = 2'd0;
                    res_timeout_n = 1'b1;
                    state_n       = RESULT;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    k_n     = 2'd0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        job_ready_n = (state_n == IDLE);
        res_valid_n = (state_n == RESULT);
        psel_n      = (state_n == SETUP) || (state_n == ACCESS);
        penable_n   = (state_n == ACCESS);
        paddr_n     = '0;
        pwdata_n    = '0;

        // CTRL goes last because writing it kicks off the ECC operation.
        if (psel_n) begin
            unique case (k_n)
                2'd0: begin paddr_n = ADDR_DATA_IN; pwdata_n = AMBA_WORD'(data_n);  end
                2'd1: begin paddr_n = ADDR_WIDTH;   pwdata_n = AMBA_WORD'(width_n); end
                2'd2: begin paddr_n = ADDR_NOISE;   pwdata_n = AMBA_WORD'(noise_n); end
                2'd3: begin paddr_n = ADDR_CTRL;    pwdata_n = AMBA_WORD'(ctrl_n);  end
                default: begin paddr_n = '0; pwdata_n = '0; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            k_q           <= 2'd0;
            cnt_q         <= '0;
            ctrl_q        <= 2'd0;
            data_q        <= '0;
            width_q       <= 2'd0;
            noise_q       <= '0;
            res_data_q    <= '0;
            res_errors_q  <= 2'd0;
            res_timeout_q <= 1'b0;
            job_ready_q   <= 1'b1;
            res_valid_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
        end else begin
            state_q       <= state_n;
            k_q           <= k_n;
            cnt_q         <= cnt_n;
            ctrl_q        <= ctrl_n;
            data_q        <= data_n;
            width_q       <= width_n;
            noise_q       <= noise_n;
            res_data_q    <= res_data_n;
            res_errors_q  <= res_errors_n;
            res_timeout_q <= res_timeout_n;
            job_ready_q   <= job_ready_n;
            res_valid_q   <= res_valid_n;
            psel_q        <= psel_n;
            penable_q     <= penable_n;
            paddr_q       <= paddr_n;
            pwdata_q      <= pwdata_n;
        end
    end

    assign job_ready   = job_ready_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_errors  = res_errors_q;
    assign res_timeout = res_timeout_q;

    assign apb.PADDR   = paddr_q;
    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = psel_q;
    assign apb.PWDATA  = pwdata_q;

endmodule

// File: tb/tb_ecc_apb_driver.sv
// Bench for ecc_apb_driver: a timeline model of the job/APB/result behaviour checked every cycle,
// plus directed jobs with hand-computed expectations.
module tb_ecc_apb_driver;

    localparam int TIMEOUT = 64;

    logic        clk;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [1:0]  job_ctrl;
    logic [31:0] job_data;
    logic [1:0]  job_width;
    logic [31:0] job_noise;
    logic        operation_done;
    logic [31:0] data_out;
    logic [1:0]  num_of_errors;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [1:0]  res_errors;
    logic        res_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    ecc_apb_driver_if #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20)) apb_if ();

    ecc_apb_driver #(
        .AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_ctrl(job_ctrl),
        .job_data(job_data), .job_width(job_width), .job_noise(job_noise),
        .apb(apb_if),
        .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_errors(res_errors), .res_timeout(res_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a job occupies cycles 1..8 after its handshake with four SETUP/ACCESS pairs,
    // then waits from cycle 9 for done or TIMEOUT cycles, then holds the result until consumed.
    bit          m_idle;
    bit          m_res;
    int          m_since;
    logic [1:0]  m_ctrl, m_width;
    logic [31:0] m_data, m_noise;
    logic [31:0] m_rdata;
    logic [1:0]  m_rerr;
    logic        m_rto;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_idle  <= 1'b1;
            m_res   <= 1'b0;
            m_since <= 0;
            m_rdata <= '0;
            m_rerr  <= '0;
            m_rto   <= 1'b0;
        end else if (m_idle) begin
            if (job_valid) begin
                m_idle  <= 1'b0;
                m_since <= 1;
                m_ctrl  <= job_ctrl;
                m_data  <= job_data;
                m_width <= job_width;
                m_noise <= job_noise;
            end
        end else if (m_res) begin
            if (res_ready) begin
                m_idle <= 1'b1;
                m_res  <= 1'b0;
            end
        end else begin
            m_since <= m_since + 1;
            if (m_since >= 9) begin
                if (operation_done) begin
                    m_res   <= 1'b1;
                    m_rdata <= data_out;
                    m_rerr  <= num_of_errors;
                    m_rto   <= 1'b0;
                end else if (m_since - 9 == TIMEOUT - 1) begin
                    m_res   <= 1'b1;
                    m_rdata <= '0;
                    m_rerr  <= '0;
                    m_rto   <= 1'b1;
                end
            end
        end
    end

    logic        e_psel, e_en;
    logic [19:0] e_addr;
    logic [31:0] e_wdata;
    int          e_idx;

    always @(negedge clk) begin
        if (rst) begin
            e_psel  = 1'b0;
            e_en    = 1'b0;
            e_addr  = '0;
            e_wdata = '0;
            if (!m_idle && m_since >= 1 && m_since <= 8) begin
                e_idx  = (m_since - 1) / 2;
                e_psel = 1'b1;
                e_en   = ((m_since - 1) % 2) == 1;
                case (e_idx)
                    0: begin e_addr = 20'h04; e_wdata = m_data; end
                    1: begin e_addr = 20'h08; e_wdata = {30'd0, m_width}; end
                    2: begin e_addr = 20'h0C; e_wdata = m_noise; end
                    default: begin e_addr = 20'h00; e_wdata = {30'd0, m_ctrl}; end
                endcase
            end
            check_output("job_ready", job_ready, m_idle);
            check_output("psel", apb_if.PSEL, e_psel);
            check_output("penable", apb_if.PENABLE, e_en);
            check_output("pwrite", apb_if.PWRITE, e_psel);
            check_output("paddr", apb_if.PADDR, e_addr);
            check_output("pwdata", apb_if.PWDATA, e_wdata);
            check_output("res_valid", res_valid, m_res);
            if (m_res) begin
                check_output("res_data", res_data, m_rdata);
                check_output("res_errors", res_errors, m_rerr);
                check_output("res_timeout", res_timeout, m_rto);
            end
        end
    end

    logic [19:0] obs_addr [8];
    logic [31:0] obs_data [8];

    task automatic tick(inout int cur);
        @(posedge clk);
        #1;
        cur++;
    endtask

    // Offers one job, optionally pulses a stale done, answers with done at wait offset
    // done_at (-1 = never), then holds res_ready low for hold cycles before consuming.
    task automatic apply_stimulus(
        input logic [1:0] ctrl, input logic [31:0] data, input logic [1:0] width,
        input logic [31:0] noise, input int done_at, input bit stale,
        input logic [31:0] dout, input logic [1:0] nerr, input int hold,
        output int lat, output logic [31:0] rdata, output logic [1:0] rerr, output logic rto
    );
        int cur;
        int guard;
        logic [31:0] exp_rd;
        job_ctrl  = ctrl;
        job_data  = data;
        job_width = width;
        job_noise = noise;
        job_valid = 1'b1;
        guard = 0;
        while (job_ready !== 1'b1 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_output("handshake_wait", job_ready, 1'b1);
        cur = 0;
        tick(cur);
        job_valid = 1'b0;
        job_ctrl  = ~ctrl;
        job_data  = ~data;
        job_width = ~width;
        job_noise = ~noise;
        for (int s = 1; s <= 8; s++) begin
            obs_addr[s-1] = apb_if.PADDR;
            obs_data[s-1] = apb_if.PWDATA;
            operation_done = stale && (s == 4);
            tick(cur);
        end
        operation_done = 1'b0;
        if (done_at >= 0) begin
            repeat (done_at) tick(cur);
            operation_done = 1'b1;
            data_out       = dout;
            num_of_errors  = nerr;
            tick(cur);
            operation_done = 1'b0;
            data_out       = 32'hDEAD_0000;
            num_of_errors  = 2'b11;
        end
        while (res_valid !== 1'b1 && cur < 9 + TIMEOUT + 10) tick(cur);
        check_output("res_valid_wait", res_valid, 1'b1);
        lat   = cur;
        rdata = res_data;
        rerr  = res_errors;
        rto   = res_timeout;
        exp_rd = (done_at >= 0) ? dout : 32'd0;
        if (hold > 0) job_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            check_output("hold_job_ready", job_ready, 1'b0);
            check_output("hold_res_data", res_data, exp_rd);
            tick(cur);
        end
        job_valid = 1'b0;
        res_ready = 1'b1;
        tick(cur);
        res_ready = 1'b0;
        check_output("after_ready_job_ready", job_ready, 1'b1);
        check_output("after_ready_res_valid", res_valid, 1'b0);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic [1:0]  re;
        logic        rt;
        int          cur;

        rst = 1'b0;
        job_valid = 1'b0; job_ctrl = '0; job_data = '0; job_width = '0; job_noise = '0;
        operation_done = 1'b0; data_out = 32'hDEAD_0000; num_of_errors = 2'b11; res_ready = 1'b0;
        #12;
        check_output("reset_job_ready", job_ready, 1'b1);
        check_output("reset_psel", apb_if.PSEL, 1'b0);
        check_output("reset_pwdata", apb_if.PWDATA, 32'd0);
        check_output("reset_res_valid", res_valid, 1'b0);
        check_output("reset_res_data", res_data, 32'd0);
        #10 rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] encode job");
        apply_stimulus(2'b00, 32'hA5, 2'b00, 32'd0, 3, 1'b0, 32'h1234, 2'b00, 0, lat, rd, re, rt);
        check_output("enc_addr0", obs_addr[0], 20'h04);
        check_output("enc_data0", obs_data[0], 32'hA5);
        check_output("enc_addr1", obs_addr[2], 20'h08);
        check_output("enc_addr2", obs_addr[4], 20'h0C);
        check_output("enc_addr3", obs_addr[6], 20'h00);
        check_output("enc_lat", lat, 13);
        check_output("enc_res_data", rd, 32'h1234);
        check_output("enc_res_to", rt, 1'b0);

        $display("[TB] full channel job");
        apply_stimulus(2'b10, 32'h0F0F, 2'b01, 32'h4, 2, 1'b0, 32'h0F0B, 2'b01, 0, lat, rd, re, rt);
        check_output("fc_noise_addr", obs_addr[4], 20'h0C);
        check_output("fc_noise_data", obs_data[4], 32'h4);
        check_output("fc_ctrl_data", obs_data[6], 32'h2);
        check_output("fc_res_errors", re, 2'b01);

        $display("[TB] timeout job");
        apply_stimulus(2'b01, 32'h55, 2'b10, 32'd0, -1, 1'b0, 32'd0, 2'b00, 0, lat, rd, re, rt);
        check_output("to_lat", lat, 73);
        check_output("to_res_to", rt, 1'b1);
        check_output("to_res_data", rd, 32'd0);

        $display("[TB] backpressure job");
        apply_stimulus(2'b11, 32'h77, 2'b11, 32'h8, 0, 1'b0, 32'h9999, 2'b10, 10, lat, rd, re, rt);
        check_output("bp_ctrl_data", obs_data[6], 32'h3);
        check_output("bp_res_data", rd, 32'h9999);

        $display("[TB] stale done job");
        apply_stimulus(2'b01, 32'h3C, 2'b00, 32'd0, 5, 1'b1, 32'hCAFE, 2'b00, 0, lat, rd, re, rt);
        check_output("stale_lat", lat, 15);
        check_output("stale_res_data", rd, 32'hCAFE);

        $display("[TB] done on last timeout cycle");
        apply_stimulus(2'b00, 32'h1, 2'b01, 32'd0, TIMEOUT - 1, 1'b0, 32'hBEEF, 2'b10, 0, lat, rd, re, rt);
        check_output("coin_lat", lat, 73);
        check_output("coin_res_to", rt, 1'b0);
        check_output("coin_res_data", rd, 32'hBEEF);

        $display("[TB] async reset mid transfer");
        job_ctrl = 2'b10; job_data = 32'h11; job_width = 2'b00; job_noise = 32'h22;
        job_valid = 1'b1;
        cur = 0;
        tick(cur);
        job_valid = 1'b0;
        cur = 1;
        while (cur < 6) tick(cur);
        check_output("rst_pre_psel", apb_if.PSEL, 1'b1);
        check_output("rst_pre_penable", apb_if.PENABLE, 1'b1);
        check_output("rst_pre_paddr", apb_if.PADDR, 20'h0C);
        #2 rst = 1'b0;
        #1;
        check_output("rst_psel", apb_if.PSEL, 1'b0);
        check_output("rst_penable", apb_if.PENABLE, 1'b0);
        check_output("rst_job_ready", job_ready, 1'b1);
        check_output("rst_res_valid", res_valid, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("post_rst_job_ready", job_ready, 1'b1);

        apply_stimulus(2'b00, 32'h5A, 2'b10, 32'd0, 1, 1'b0, 32'h4321, 2'b00, 0, lat, rd, re, rt);
        check_output("post_rst_lat", lat, 11);
        check_output("post_rst_res_data", rd, 32'h4321);

        #20;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got stuck, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ecc_apb_driver.md
# ecc_apb_driver

Upstream stimulus stage for the ECC encoder/decoder top. Accepts one job (mode, data, codeword width, noise) on a valid/ready port. Converts it into a fixed sequence of four APB write transfers to the ECC register bank, then waits for `operation_done`. Captures `data_out`/`num_of_errors` (or flags a timeout) and returns them on a valid/ready result port.

## Interface
- `AMBA_WORD`, 32, APB data width
- `AMBA_ADDR_WIDTH`, 20, APB address width
- `DATA_WIDTH`, 32, ECC data/codeword width (≤ `AMBA_WORD`)
- `TIMEOUT_CYCLES`, 64, max WAIT_DONE cycles before timeout (≥ 1)

Ports (clock and reset first):
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `job_valid`  in  1  job offered
- `job_ready`  out  1  driver idle, job accepted when `job_valid&job_ready`
- `job_ctrl`  in  2  CTRL mode (00 enc, 01 dec, 10 full channel)
- `job_data`  in  DATA_WIDTH  DATA_IN value
- `job_width`  in  2  CODEWORD_WIDTH value
- `job_noise`  in  DATA_WIDTH  NOISE value
- `PADDR`  out  AMBA_ADDR_WIDTH  APB address
- `PSEL`, `PENABLE`, `PWRITE`  out  1 each  APB control
- `PWDATA`  out  AMBA_WORD  APB write data
- `operation_done`  in  1  from ECC top
- `data_out`  in  DATA_WIDTH  from ECC top
- `num_of_errors`  in  2  from ECC top
- `res_valid`  out  1  result available
- `res_ready`  in  1  result consumed when `res_valid&res_ready`
- `res_data`  out  DATA_WIDTH  captured `data_out`
- `res_errors`  out  2  captured `num_of_errors`
- `res_timeout`  out  1  1 = no `operation_done` seen

## Operation
- States: IDLE, SETUP, ACCESS, WAIT_DONE, RESULT.
- IDLE:
  - `job_ready`=1.
  - On handshake, latch all job fields, set write index k=0, go SETUP.
- Write sequence, fixed order:
  - k=0: DATA_IN @0x04
  - k=1: CODEWORD_WIDTH @0x08
  - k=2: NOISE @0x0C
  - k=3: CTRL @0x00
  - CTRL is last because the CTRL write starts the operation.
- Write data: field zero-extended to `AMBA_WORD`. All four registers are always written, regardless of mode.
- SETUP:
  - `PSEL`=1, `PENABLE`=0, `PWRITE`=1, `PADDR`/`PWDATA` valid.
  - Next cycle go ACCESS.
- ACCESS:
  - Same as SETUP with `PENABLE`=1. Single cycle; the bank has no wait states.
  - k<3: k++, go SETUP. k=3: clear timeout counter, go WAIT_DONE.
- WAIT_DONE:
  - APB idle: `PSEL`=`PENABLE`=`PWRITE`=0, `PADDR`=0, `PWDATA`=0.
  - If `operation_done`=1: capture `data_out`, `num_of_errors`, `res_timeout`=0, go RESULT.
  - Else if counter == `TIMEOUT_CYCLES`-1: `res_data`=0, `res_errors`=0, `res_timeout`=1, go RESULT.
  - Else counter++.
  - `operation_done` and timeout in the same cycle: done wins.
- RESULT:
  - `res_valid`=1, result registers stable.
  - On `res_ready`=1 go IDLE.
- `operation_done` outside WAIT_DONE is ignored (stale from a previous op).
- `job_ctrl`=11 is forwarded unchanged; the ECC top treats it as encode.
- Inputs `job_*` are sampled only at the handshake; later changes have no effect.

## Timing
- Reset values: `job_ready`=1, `PSEL`=`PENABLE`=`PWRITE`=0, `PADDR`=0, `PWDATA`=0, `res_valid`=0, `res_data`=0, `res_errors`=0, `res_timeout`=0. State IDLE, k=0, counter=0.
- Reset mid-transaction drops the APB transfer immediately (async) and discards the job and result.
- All outputs are registered; no combinational input→output path.
- Handshake at edge T:
  - SETUP k0 at T+1, ACCESS k0 at T+2, …, ACCESS CTRL at T+8.
  - WAIT_DONE from T+9.
- `operation_done` high in WAIT_DONE cycle C gives `res_valid`=1 from C+1.
- Timeout: with no done, `res_valid` rises at T+9+`TIMEOUT_CYCLES`.
- `res_valid&res_ready` at edge R gives `job_ready`=1 from R+1. There is no same-cycle result→job turnaround.
- Throughput: at most one job in flight.

## Test plan
- Reset then encode job: ctrl=00, data=0x0000_00A5, width=00, noise=0 → 8 APB cycles, addresses 0x04,0x08,0x0C,0x00 with PWDATA 0xA5,0,0,0. Model asserts done 3 cycles later with data_out=0x1234 → `res_data`=0x1234, `res_errors`=0, `res_timeout`=0.
- Full channel: ctrl=10, noise=0x0000_0004, model returns num_of_errors=01 → `res_errors`=01. PWDATA of the NOISE write = 0x4.
- Timeout: TIMEOUT_CYCLES=64, done never asserted → `res_valid` at T+73 with `res_timeout`=1, `res_data`=0.
- Backpressure: hold `res_ready`=0 for 10 cycles → result stable, `job_ready`=0. A new `job_valid` is not accepted until the cycle after `res_ready`.
- Stale done / coincidence:
  - `operation_done` pulsed during ACCESS k1 → ignored.
  - Done on the final timeout cycle → `res_timeout`=0, data captured.
- Async reset asserted at ACCESS k2 → `PSEL`/`PENABLE` drop without a clock edge. After release, `job_ready`=1 and `res_valid`=0.
